jenc_rle: RTL and testbench
===========================

# jenc_rle

Run-length / DC-prediction stage of the JPEG encoder, directly downstream of the quantizer. It accepts quantized coefficient pairs in zigzag order, one 8x8 block per 32 beats. It produces one JPEG entropy symbol per cycle (run, size, amplitude), handling DC differential coding per component, ZRL and EOB insertion. Its output feeds the Huffman coder.

## Interface
Parameters:
- QW, 11: quantized coefficient width
- AW, 11: amplitude width; must be QW.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous and active-low
- q  in  2x QW signed  coefficient pair; q[0] is zigzag index 2*q_cnt, q[1] is 2*q_cnt+1
- q_valid  in  1  pair valid
- q_hold  out  1  back-pressure to the quantizer
- q_cnt  in  5  pair index within the block, 0..31
- q_chroma  in  2  0=Y, 1=Cb, 2=Cr
- q_last_mcu  in  1  block is the final (Cr) block of the image
- rl_run  out  4  zero run preceding the coefficient
- rl_size  out  4  JPEG magnitude category, 0..11
- rl_amp  out  AW  amplitude bits, right-aligned, upper bits zero
- rl_dc  out  1  symbol is a DC difference
- rl_chroma  out  2  component of the symbol
- rl_last  out  1  final symbol of the image
- rl_valid  out  1  symbol valid
- rl_hold  in  1  back-pressure from the Huffman coder

## Operation
- Pair buffer: one entry. A beat is accepted when q_valid & ~q_hold. The buffer holds the pair plus cnt, chroma and last_mcu. Select bit sel = 0 first, then 1.
- Coefficient step: one coefficient is evaluated per cycle. The step requires a free output slot: out_free = ~rl_valid | ~rl_hold.
- DC (cnt 0, sel 0):
  - diff = coef − pred[chroma], computed at QW+1 bits.
  - Emit run=0, size=mag(diff), rl_dc=1.
  - pred[chroma] ← coef.
  - run ← 0.
- AC coefficient zero:
  - If index 63 and run counter > 0, or index 63 alone: emit EOB (run 0, size 0). Pending ZRLs are discarded.
  - Otherwise run ← run+1 and nothing is emitted.
- AC coefficient nonzero:
  - If run ≥ 16: emit ZRL (run 15, size 0), run ← run−16. The coefficient is not consumed; re-evaluate next cycle.
  - Else: emit run=run, size=mag(coef), run ← 0.
- Index 63 nonzero: the symbol is emitted and no EOB follows.
- mag(x): bit length of |x| (0 for x=0). amp = x if x ≥ 0, else (x−1) masked to size bits.
- rl_last: set on the final symbol (EOB, or coefficient 63) of a block with q_last_mcu=1. After that symbol is emitted, all three pred are cleared to 0.
- Consumption: a step is consumed when it completes with no ZRL pending. Consuming sel=1 frees the buffer.

## Timing
- Reset values:
  - rl_valid=0, rl_run=0, rl_size=0, rl_amp=0, rl_dc=0, rl_chroma=0, rl_last=0.
  - q_hold=0.
  - pred[0..2]=0, run=0, sel=0, buffer empty.
- q_hold = buf_full & ~(sel==1 & consume). A new beat loads in the same cycle the previous one drains.
- Minimum rate is 2 cycles per beat. Each ZRL adds 1 cycle.
- Latency: beat accepted at cycle T gives its DC symbol with rl_valid high at T+2. This holds with rl_hold low throughout.
- Output is registered. While rl_valid & rl_hold, all rl_* outputs are stable and no step executes.
- Reset asserted mid-block clears state immediately. The next accepted beat is treated per its q_cnt; no resync logic.

## Configuration
- JENC_RLE_SEQ_CHECK_EN defined: simulation assertions are compiled in. They check:
  - accepted q_cnt increments 0..31 and wraps;
  - q_chroma is constant within a block;
  - q_chroma order per MCU is Y,Y,Y,Y,Cb,Cr.
  Violations call $error.
- Undefined: no checks, and the RTL is otherwise identical.

## Structure
- Shared package jenc_pkg:
  - typedef rl_sym_t {run, size, amp, dc, chroma, last};
  - constants EOB_RUN=0, ZRL_RUN=15, MAX_SIZE=11.
- Sub-module jenc_magnitude: combinational; signed input to size and amp. It is instantiated once, shared by the DC and AC paths.
- Top contains the pair buffer, run counter, predictors and output register.

## Test plan
- Single Y block: DC=5, all AC=0, pred=0 → two symbols: {dc, size 3, amp 5}, then EOB {run 0, size 0}.
- Two consecutive Y blocks with DC 5 then 2 → second DC diff −3 → size 2, amp 0b00.
- AC pattern index 1 = −1, index 40 = 7, remainder zero:
  - {run 0, size 1, amp 0};
  - ZRL, ZRL (run 38 → 6);
  - {run 6, size 3, amp 7};
  - EOB.
- Index 63 = 1, all other AC zero: three ZRLs, then {run 14, size 1, amp 1}, and no EOB.
- rl_hold high for 5 cycles mid-block → outputs frozen, q_hold asserted, no symbol lost or duplicated.
- Final Cr block with q_last_mcu=1 → rl_last is set only on its EOB. The next frame's first Y DC=4 gives size 3, amp 4 (predictors cleared).

Source files
------------

// File: rtl/jenc_pkg.sv
// Shared symbol type and JPEG entropy constants for the encoder's run-length stage.
package jenc_pkg;

  localparam int SYM_AW = 11;

  localparam logic [3:0] EOB_RUN  = 4'd0;
  localparam logic [3:0] ZRL_RUN  = 4'd15;
  localparam logic [3:0] MAX_SIZE = 4'd11;

  typedef struct packed {
    logic [3:0]        run;
    logic [3:0]        size;
    logic [SYM_AW-1:0] amp;
    logic              dc;
    logic [1:0]        chroma;
    logic              last;
  } rl_sym_t;

endpackage

// File: rtl/jenc_magnitude.sv
// JPEG magnitude category and right-aligned amplitude bits for a signed value.
module jenc_magnitude
  import jenc_pkg::*;
#(
  parameter int IW = 12,
  parameter int AW = 11
) (
  input  logic signed [IW-1:0] x,
  output logic [3:0]           size,
  output logic [AW-1:0]        amp
);

  localparam logic [IW-1:0] ONE = {{(IW-1){1'b0}}, 1'b1};

  logic [SYM_AW-1:0] abs_v;
  logic [IW-1:0]     adj;
  logic [IW-1:0]     mask;

  // Negative values carry x-1, i.e. the ones' complement of |x| in the low size bits.
  always_comb begin
    abs_v = SYM_AW'(x[IW-1] ? -x : x);
    size  = 4'd0;
    for (int i = 0; i < int'(MAX_SIZE); i++) begin
      size = abs_v[i] ? 4'(i + 1) : size;
    end
    adj  = x[IW-1] ? (x + {IW{1'b1}}) : x;
    mask = (ONE << size) - ONE;
    amp  = AW'(adj & mask);
  end

endmodule

// File: rtl/jenc_rle.sv
// JPEG run-length / DC-prediction stage: zigzag coefficient pairs in, entropy symbols out.
// Define JENC_RLE_SEQ_CHECK_EN to compile in the input block-sequence checker.
`ifdef JENC_RLE_SEQ_CHECK_EN
module jenc_rle_seq_chk (
  input logic       clk,
  input logic       resetn,
  input logic       accept,
  input logic [4:0] cnt,
  input logic [1:0] chroma
);
  logic       seen_q;
  logic [4:0] cnt_q;
  logic [1:0] chroma_q;
  logic [2:0] pos_q;
  logic [1:0] exp_chroma;

  assign exp_chroma = (pos_q < 3'd4) ? 2'd0 : ((pos_q == 3'd4) ? 2'd1 : 2'd2);

  // Pair counter continuity, constant component per block and Y,Y,Y,Y,Cb,Cr MCU order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_q   <= 1'b0;
      cnt_q    <= 5'd0;
      chroma_q <= 2'd0;
      pos_q    <= 3'd0;
    end else if (accept) begin
      if (seen_q && (cnt != cnt_q + 5'd1)) $error("jenc_rle: pair index %0d after %0d", cnt, cnt_q);
      if (seen_q && (cnt != 5'd0) && (chroma != chroma_q)) $error("jenc_rle: component changed inside block");
      if (cnt == 5'd0) begin
        if (chroma != exp_chroma) $error("jenc_rle: component %0d out of MCU order", chroma);
        pos_q <= (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
      end
      seen_q   <= 1'b1;
      cnt_q    <= cnt;
      chroma_q <= chroma;
    end
  end
endmodule
`endif

module jenc_rle
  import jenc_pkg::*;
#(
  parameter int QW = 11,
  parameter int AW = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic signed [QW-1:0] q [2],
  input  logic                 q_valid,
  output logic                 q_hold,
  input  logic [4:0]           q_cnt,
  input  logic [1:0]           q_chroma,
  input  logic                 q_last_mcu,
  output logic [3:0]           rl_run,
  output logic [3:0]           rl_size,
  output logic [AW-1:0]        rl_amp,
  output logic                 rl_dc,
  output logic [1:0]           rl_chroma,
  output logic                 rl_last,
  output logic                 rl_valid,
  input  logic                 rl_hold
);

  logic                 buf_full_q, buf_full_d;
  logic signed [QW-1:0] buf_q [2];
  logic signed [QW-1:0] buf_d [2];
  logic [4:0]           cnt_q, cnt_d;
  logic [1:0]           chroma_q, chroma_d;
  logic                 last_q, last_d;
  logic                 sel_q, sel_d;
  logic [5:0]           run_q, run_d;
  logic signed [QW-1:0] pred_q [3];
  logic signed [QW-1:0] pred_d [3];
  rl_sym_t              sym_q, sym_d, new_sym;
  logic                 valid_q, valid_d;

  logic                 out_free, step, consume, accept, emit;
  logic                 is_dc, is_end, coef_zero, zrl;
  logic signed [QW-1:0] coef, pred_cur;
  logic signed [QW:0]   mag_in;
  logic [3:0]           mag_size;
  logic [AW-1:0]        mag_amp;

  assign out_free  = ~valid_q | ~rl_hold;
  assign step      = buf_full_q & out_free;
  assign coef      = sel_q ? buf_q[1] : buf_q[0];
  assign is_dc     = ({cnt_q, sel_q} == 6'd0);
  assign is_end    = ({cnt_q, sel_q} == 6'd63);
  assign coef_zero = (coef == {QW{1'b0}});
  // A nonzero AC coefficient behind 16+ zeros stays put while ZRLs drain the run.
  assign zrl       = ~is_dc & ~coef_zero & (run_q >= 6'd16);
  assign consume   = step & ~zrl;
  assign q_hold    = buf_full_q & ~(sel_q & consume);
  assign accept    = q_valid & ~q_hold;

  // Predictor of the buffered block's component.
  always_comb begin
    case (chroma_q)
      2'd1:    pred_cur = pred_q[1];
      2'd2:    pred_cur = pred_q[2];
      default: pred_cur = pred_q[0];
    endcase
  end

  assign mag_in = is_dc ? ({coef[QW-1], coef} - {pred_cur[QW-1], pred_cur}) : {coef[QW-1], coef};

  jenc_magnitude #(.IW(QW + 1), .AW(AW)) u_mag (
    .x    (mag_in),
    .size (mag_size),
    .amp  (mag_amp)
  );

  // Coefficient step, buffer handshake and output register next-state.
  always_comb begin
    buf_full_d     = buf_full_q;
    buf_d          = buf_q;
    cnt_d          = cnt_q;
    chroma_d       = chroma_q;
    last_d         = last_q;
    sel_d          = sel_q;
    run_d          = run_q;
    pred_d         = pred_q;
    sym_d          = sym_q;
    valid_d        = valid_q;
    emit           = 1'b0;
    new_sym.run    = EOB_RUN;
    new_sym.size   = 4'd0;
    new_sym.amp    = {SYM_AW{1'b0}};
    new_sym.dc     = 1'b0;
    new_sym.chroma = chroma_q;
    new_sym.last   = 1'b0;

    if (step) begin
      if (is_dc) begin
        emit         = 1'b1;
        new_sym.size = mag_size;
        new_sym.amp  = SYM_AW'(mag_amp);
        new_sym.dc   = 1'b1;
        run_d        = 6'd0;
        case (chroma_q)
          2'd1:    pred_d[1] = coef;
          2'd2:    pred_d[2] = coef;
          default: pred_d[0] = coef;
        endcase
      end else if (coef_zero) begin
        if (is_end) begin
          emit         = 1'b1;
          new_sym.last = last_q;
          run_d        = 6'd0;
        end else begin
          run_d = run_q + 6'd1;
        end
      end else if (zrl) begin
        emit        = 1'b1;
        new_sym.run = ZRL_RUN;
        run_d       = run_q - 6'd16;
      end else begin
        emit         = 1'b1;
        new_sym.run  = run_q[3:0];
        new_sym.size = mag_size;
        new_sym.amp  = SYM_AW'(mag_amp);
        new_sym.last = is_end & last_q;
        run_d        = 6'd0;
      end
    end else begin
      emit = 1'b0;
    end

    // The image's final symbol restarts DC prediction for the next frame.
    if (emit & new_sym.last) begin
      pred_d[0] = {QW{1'b0}};
      pred_d[1] = {QW{1'b0}};
      pred_d[2] = {QW{1'b0}};
    end else begin
      pred_d = pred_d;
    end

    if (accept) begin
      buf_full_d = 1'b1;
      buf_d[0]   = q[0];
      buf_d[1]   = q[1];
      cnt_d      = q_cnt;
      chroma_d   = q_chroma;
      last_d     = q_last_mcu;
      sel_d      = 1'b0;
    end else if (consume & sel_q) begin
      buf_full_d = 1'b0;
      sel_d      = 1'b0;
    end else if (consume) begin
      sel_d = 1'b1;
    end else begin
      sel_d = sel_q;
    end

    if (out_free) begin
      valid_d = emit;
      sym_d   = emit ? new_sym : sym_q;
    end else begin
      valid_d = valid_q;
      sym_d   = sym_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_full_q <= 1'b0;
      buf_q[0]   <= {QW{1'b0}};
      buf_q[1]   <= {QW{1'b0}};
      cnt_q      <= 5'd0;
      chroma_q   <= 2'd0;
      last_q     <= 1'b0;
      sel_q      <= 1'b0;
      run_q      <= 6'd0;
      pred_q[0]  <= {QW{1'b0}};
      pred_q[1]  <= {QW{1'b0}};
      pred_q[2]  <= {QW{1'b0}};
      sym_q      <= {$bits(rl_sym_t){1'b0}};
      valid_q    <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      chroma_q   <= chroma_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      run_q      <= run_d;
      pred_q     <= pred_d;
      sym_q      <= sym_d;
      valid_q    <= valid_d;
    end
  end

  assign rl_run    = sym_q.run;
  assign rl_size   = sym_q.size;
  assign rl_amp    = AW'(sym_q.amp);
  assign rl_dc     = sym_q.dc;
  assign rl_chroma = sym_q.chroma;
  assign rl_last   = sym_q.last;
  assign rl_valid  = valid_q;

`ifdef JENC_RLE_SEQ_CHECK_EN
  jenc_rle_seq_chk u_seq_chk (
    .clk    (clk),
    .resetn (resetn),
    .accept (accept),
    .cnt    (q_cnt),
    .chroma (q_chroma)
  );
`endif

endmodule

// File: tb/tb_jenc_rle.sv
// Scoreboard bench for jenc_rle: a block-level JPEG symbol model feeds an expected queue.
module tb_jenc_rle;

  localparam int QW = 11;
  localparam int AW = 11;
  localparam int HOLD_BLK = 4;

  typedef struct packed {
    logic [3:0]    run;
    logic [3:0]    size;
    logic [AW-1:0] amp;
    logic          dc;
    logic [1:0]    chroma;
    logic          last;
  } sym_t;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic signed [QW-1:0] q [2];
  logic                 q_valid, q_hold, q_last_mcu;
  logic [4:0]           q_cnt;
  logic [1:0]           q_chroma;
  logic [3:0]           rl_run, rl_size;
  logic [AW-1:0]        rl_amp;
  logic                 rl_dc, rl_last, rl_valid, rl_hold;
  logic [1:0]           rl_chroma;

  sym_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pred[3];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   blk_no = 0;
  int   hold_mode = 2;
  bit   hold_go = 1'b0;
  bit   mon_en = 1'b0;
  bit   lat_pending = 1'b0;
  bit   lat_mon_pending = 1'b0;

  jenc_rle #(.QW(QW), .AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .q          (q),
    .q_valid    (q_valid),
    .q_hold     (q_hold),
    .q_cnt      (q_cnt),
    .q_chroma   (q_chroma),
    .q_last_mcu (q_last_mcu),
    .rl_run     (rl_run),
    .rl_size    (rl_size),
    .rl_amp     (rl_amp),
    .rl_dc      (rl_dc),
    .rl_chroma  (rl_chroma),
    .rl_last    (rl_last),
    .rl_valid   (rl_valid),
    .rl_hold    (rl_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mag(input int x);
    int a;
    int s;
    a = (x < 0) ? -x : x;
    s = 0;
    while (a > 0) begin
      s++;
      a = a >> 1;
    end
    return s;
  endfunction

  function automatic sym_t mk(input int run, input int x, input bit dc, input int ch, input bit last);
    sym_t s;
    int   sz;
    sz       = mag(x);
    s.run    = 4'(run);
    s.size   = 4'(sz);
    s.amp    = AW'((x >= 0) ? x : x + (1 << sz) - 1);
    s.dc     = dc;
    s.chroma = 2'(ch);
    s.last   = last;
    return s;
  endfunction

  // Reference: JPEG DC differencing plus AC run-length coding with ZRL/EOB.
  task automatic model_block(input int c[64], input int ch, input bit last);
    int run;
    exp_q.push_back(mk(0, c[0] - pred[ch], 1'b1, ch, 1'b0));
    pred[ch] = c[0];
    run = 0;
    for (int i = 1; i < 64; i++) begin
      if (c[i] == 0) begin
        if (i == 63) exp_q.push_back(mk(0, 0, 1'b0, ch, last));
        else run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk(15, 0, 1'b0, ch, 1'b0));
          run -= 16;
        end
        exp_q.push_back(mk(run, c[i], 1'b0, ch, last && (i == 63)));
        run = 0;
      end
    end
    if (last) begin
      pred[0] = 0;
      pred[1] = 0;
      pred[2] = 0;
    end
  endtask

  task automatic rand_block(output int c[64]);
    int dens;
    int v;
    int r;
    r = int'($urandom_range(0, 9));
    c[0] = (r == 0) ? -1024 : ((r == 1) ? 1023 : int'($urandom_range(0, 2047)) - 1024);
    dens = int'($urandom_range(2, 45));
    for (int i = 1; i < 64; i++) begin
      if (int'($urandom_range(0, 99)) < dens) begin
        v = ($urandom_range(0, 99) < 75) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 1023));
        c[i] = ($urandom_range(0, 1) == 1) ? -v : v;
      end else begin
        c[i] = 0;
      end
    end
  endtask

  task automatic send_block(input int c[64], input int ch, input bit last, input int gap_max);
    bit acc;
    int t;
    model_block(c, ch, last);
    for (int k = 0; k < 32; k++) begin
      q[0]       = QW'(c[2*k]);
      q[1]       = QW'(c[2*k+1]);
      q_cnt      = 5'(k);
      q_chroma   = 2'(ch);
      q_last_mcu = last;
      q_valid    = 1'b1;
      if (blk_no == HOLD_BLK && k == 10) hold_go = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = !q_hold;
        if (acc && lat_pending) begin
          acc_cyc = cyc;
          lat_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        t++;
        if (!acc && t > 300) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: block %0d pair %0d not accepted after %0d cycles", blk_no, k, t);
          acc = 1'b1;
        end
      end
      if (gap_max > 0) begin
        q_valid = 1'b0;
        repeat (int'($urandom_range(0, gap_max))) begin
          @(posedge clk);
          #1;
        end
      end
    end
    q_valid = 1'b0;
    blk_no++;
  endtask

  // Back-pressure: one directed 5-cycle stall, later random stalls.
  initial begin
    rl_hold = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_mode == 1) begin
        rl_hold = ($urandom_range(0, 99) < 35);
      end else if (hold_mode == 2 && hold_go) begin
        hold_go = 1'b0;
        rl_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (i >= 2) begin
            checks++;
            if (q_hold !== 1'b1) begin
              errors++;
              $display("FAIL hold_qhold: q_hold=%b during stall cycle %0d, want 1", q_hold, i);
            end
          end
          @(posedge clk);
          #1;
        end
        rl_hold = 1'b0;
        hold_mode = 0;
      end else begin
        rl_hold = 1'b0;
      end
    end
  end

  // Monitor: pops the expected queue on every accepted symbol.
  initial begin
    sym_t cur;
    sym_t e;
    sym_t held;
    bit   held_prev;
    held_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur.run = rl_run;
      cur.size = rl_size;
      cur.amp = rl_amp;
      cur.dc = rl_dc;
      cur.chroma = rl_chroma;
      cur.last = rl_last;
      if (mon_en) begin
        if (held_prev) begin
          checks++;
          if (!rl_valid || cur !== held) begin
            errors++;
            $display("FAIL hold_stable: got valid=%b sym=%h, want valid=1 sym=%h", rl_valid, cur, held);
          end
        end
        if (rl_valid && lat_mon_pending) begin
          lat_mon_pending = 1'b0;
          checks++;
          if (cyc != acc_cyc + 2) begin
            errors++;
            $display("FAIL latency: first symbol %0d cycles after accept, want 2", cyc - acc_cyc);
          end
        end
        if (rl_valid && !rl_hold) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_sym: got run=%0d size=%0d amp=%h, want no symbol", cur.run, cur.size, cur.amp);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL sym: got run=%0d size=%0d amp=%h dc=%b ch=%0d last=%b, want run=%0d size=%0d amp=%h dc=%b ch=%0d last=%b",
                       cur.run, cur.size, cur.amp, cur.dc, cur.chroma, cur.last,
                       e.run, e.size, e.amp, e.dc, e.chroma, e.last);
            end
          end
        end
        held_prev = rl_valid && rl_hold;
        held = cur;
      end
    end
  end

  initial begin
    int c[64];
    int t;
    bit last;
    pred[0] = 0;
    pred[1] = 0;
    pred[2] = 0;
    resetn = 1'b0;
    q_valid = 1'b0;
    q[0] = '0;
    q[1] = '0;
    q_cnt = 5'd0;
    q_chroma = 2'd0;
    q_last_mcu = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rl_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rl_valid); end
    checks++;
    if ({rl_run, rl_size, rl_amp, rl_dc, rl_chroma, rl_last} !== '0) begin
      errors++;
      $display("FAIL reset_fields: got %h want 0", {rl_run, rl_size, rl_amp, rl_dc, rl_chroma, rl_last});
    end
    checks++;
    if (q_hold !== 1'b0) begin errors++; $display("FAIL reset_qhold: got %b want 0", q_hold); end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;
    lat_pending = 1'b1;
    lat_mon_pending = 1'b1;

    // MCU 1: directed Y blocks, stalled dense Cb, final Cr of the image.
    c = '{default: 0};
    c[0] = 5;
    send_block(c, 0, 1'b0, 0);
    c[0] = 2;
    send_block(c, 0, 1'b0, 0);
    c[1] = -1;
    c[40] = 7;
    send_block(c, 0, 1'b0, 0);
    c = '{default: 0};
    c[63] = 1;
    send_block(c, 0, 1'b0, 0);
    for (int i = 0; i < 64; i++) begin
      c[i] = int'($urandom_range(1, 900));
      if ($urandom_range(0, 1) == 1) c[i] = -c[i];
    end
    send_block(c, 1, 1'b0, 0);
    rand_block(c);
    c[63] = 0;
    send_block(c, 2, 1'b1, 0);

    // MCU 2: new frame, predictors start from zero.
    c = '{default: 0};
    c[0] = 4;
    send_block(c, 0, 1'b0, 0);
    for (int b = 1; b < 6; b++) begin
      rand_block(c);
      send_block(c, (b < 4) ? 0 : b - 3, 1'b0, 0);
    end

    // Random MCUs under random back-pressure and input gaps.
    hold_mode = 1;
    for (int m = 0; m < 8; m++) begin
      for (int b = 0; b < 6; b++) begin
        rand_block(c);
        last = (b == 5) && (m == 3 || m == 7);
        send_block(c, (b < 4) ? 0 : b - 3, last, 2);
      end
    end

    hold_mode = 0;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d symbols still expected, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
